// File: rtl/voice_allocator.sv
// Voice allocator: debounces 12 raw key bits and maps up to three held
// keys onto three note-code voices, with optional oldest-voice stealing.
//
// Ports:
//   clk_in      - system clock
//   rst_in      - synchronous active-high reset
//   keys_in     - raw key vector, bit i = note code i+1
//   note_1_out  - voice 1 note code (0 = silent, 1..12 = C4..B4)
//   note_2_out  - voice 2 note code
//   note_3_out  - voice 3 note code
//   busy_out    - bit v set when voice v+1 holds a note
//   dropped_out - one-cycle pulse when a press finds no voice
module voice_allocator #(
   parameter int unsigned DEBOUNCE_CYCLES = 65536,
   parameter bit          STEAL_EN        = 1'b1,
   parameter int unsigned AGE_W           = 24
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [11:0] keys_in,
   output logic [3:0]  note_1_out,
   output logic [3:0]  note_2_out,
   output logic [3:0]  note_3_out,
   output logic [2:0]  busy_out,
   output logic        dropped_out
);

   // The counter flips the key instead of reaching DEBOUNCE_CYCLES,
   // so it only has to hold DEBOUNCE_CYCLES-1.
   localparam int unsigned CNT_W =
      (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [11:0]            db_q, db_d;
   logic [11:0]            prev_q;
   logic [11:0]            rise_q, fall_q;
   logic [11:0]            pend_q, pend_d;
   logic [11:0][CNT_W-1:0] cnt_q, cnt_d;

   logic [2:0][3:0]        note_q, note_d, note_rel;
   logic [2:0][AGE_W-1:0]  age_q, age_d;
   logic [2:0][11:0]       held;
   logic [2:0]             busy_q, busy_d;
   logic [2:0]             free, load;
   logic                   drop_q, drop_d;

   logic [11:0]            cand, svc_oh;
   logic [3:0]             svc_code;
   logic                   svc_vld, svc_held;
   logic [1:0]             free_idx, old_idx, tgt_idx;
   logic                   tgt_vld;

   // Per-key debounce
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      for (int i = 0; i < 12; i++) begin
         if (keys_in[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               db_d[i] = ~db_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Release, service and allocation
   always_comb begin
      held = '0;
      for (int v = 0; v < 3; v++) begin
         for (int k = 0; k < 12; k++) begin
            if (note_q[v] == 4'(k + 1)) begin
               held[v][k] = 1'b1;
            end
         end
      end

      // Releases land first so a freed voice serves this cycle.
      for (int v = 0; v < 3; v++) begin
         note_rel[v] = (|(held[v] & fall_q)) ? 4'd0 : note_q[v];
         free[v]     = (note_rel[v] == 4'd0);
      end

      // A press withdrawn this cycle is never serviced.
      cand    = pend_q & ~fall_q;
      svc_oh  = cand & (~cand + 12'd1);
      svc_vld = |cand;

      svc_code = '0;
      for (int k = 0; k < 12; k++) begin
         if (svc_oh[k]) begin
            svc_code = 4'(k + 1);
         end
      end

      svc_held = 1'b0;
      for (int v = 0; v < 3; v++) begin
         if (svc_vld && note_rel[v] == svc_code) begin
            svc_held = 1'b1;
         end
      end

      if (free[0]) begin
         free_idx = 2'd0;
      end else if (free[1]) begin
         free_idx = 2'd1;
      end else begin
         free_idx = 2'd2;
      end

      // Strict compare keeps ties on the lower voice.
      old_idx = 2'd0;
      if (age_q[1] > age_q[0]) begin
         old_idx = 2'd1;
      end
      if (age_q[2] > age_q[old_idx]) begin
         old_idx = 2'd2;
      end

      tgt_vld = svc_vld & ~svc_held & ((|free) | STEAL_EN);
      tgt_idx = (|free) ? free_idx : old_idx;
      drop_d  = svc_vld & ~svc_held & ~(|free) & ~STEAL_EN;

      load = '0;
      if (tgt_vld) begin
         load[tgt_idx] = 1'b1;
      end

      for (int v = 0; v < 3; v++) begin
         note_d[v] = load[v] ? svc_code : note_rel[v];
         busy_d[v] = (note_d[v] != 4'd0);
         age_d[v]  = '0;
         if (!load[v] && busy_d[v]) begin
            age_d[v] = (&age_q[v]) ? age_q[v] : age_q[v] + 1'b1;
         end
      end

      pend_d = (pend_q & ~fall_q & ~svc_oh) | rise_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         db_q   <= '0;
         prev_q <= '0;
         rise_q <= '0;
         fall_q <= '0;
         pend_q <= '0;
         cnt_q  <= '0;
         note_q <= '0;
         age_q  <= '0;
         busy_q <= '0;
         drop_q <= 1'b0;
      end else begin
         db_q   <= db_d;
         prev_q <= db_q;
         rise_q <= db_q & ~prev_q;
         fall_q <= ~db_q & prev_q;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         note_q <= note_d;
         age_q  <= age_d;
         busy_q <= busy_d;
         drop_q <= drop_d;
      end
   end

   assign note_1_out  = note_q[0];
   assign note_2_out  = note_q[1];
   assign note_3_out  = note_q[2];
   assign busy_out    = busy_q;
   assign dropped_out = drop_q;

endmodule
